ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage of the 16-bit CPU, directly upstream of the controller.
//  - Fetches 16-bit instructions over a req/ack instruction-memory port.
//  - Presents one instruction per cycle with valid/ready; drives id_opcode to the controller.
//  - Consumes the controller's pc_sel to redirect on BEQZ (opcode 12). 2-entry buffer (IR+PB).
// PARAMETERS
//  AW        12  instruction address width (word addressed)
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset, asynchronous, active-low
//  imem_req   out  1   fetch request; held high, imem_addr stable, until imem_ack
//  imem_addr  out  AW  fetch address
//  imem_ack   in   1   one-cycle pulse; imem_rdata valid in same cycle
//  imem_rdata in   16  fetched instruction
//  id_valid   out  1   IR holds a valid instruction
//  id_ready   in   1   downstream accepts; consume = id_valid & id_ready
//  id_instr   out  16  IR contents
//  id_opcode  out  4   id_instr[15:12], to controller
//  id_pc      out  AW  address of id_instr
//  pc_sel     in   1   branch taken (controller); sampled only on consume
//  illegal    out  1   sticky illegal-opcode flag (0 when FETCH_ILLEGAL_TRAP_EN undefined)
// BEHAVIOUR
//  - Reset (async, immediate): state=S_IDLE; fpc=RESET_PC; IR/PB invalid; id_instr=0;
//    id_pc=0; imem_req=0; id_valid=0; illegal=0. S_IDLE -> S_REQ next cycle.
//  - imem_req=1 in S_REQ, S_BOTH, S_DROP; imem_addr=fpc (held pc in S_DROP). Max 1 outstanding.
//  - br_target = id_pc + 1 + sext(id_instr[5:0]), modulo 2^AW. fpc increments wrap 2^AW-1 -> 0.
//  - S_REQ (IR empty): ack -> IR<=rdata, id_pc<=fpc, fpc+1, -> S_BOTH.
//  - S_BOTH (IR full, prefetch at fpc):
//    consume&pc_sel&ack   -> drop rdata, IR clr, fpc<=br_target, -> S_REQ
//    consume&pc_sel&!ack  -> IR clr, tgt<=br_target, -> S_DROP
//    consume&!pc_sel&ack  -> IR<=rdata, fpc+1, stay (1 instr/cycle)
//    consume&!pc_sel&!ack -> IR clr, -> S_REQ (same request continues)
//    !consume&ack         -> PB<=rdata (+pc), fpc+1, -> S_FULL
//  - S_FULL (IR+PB full, req=0): consume&pc_sel -> flush PB, fpc<=br_target, -> S_REQ;
//    consume&!pc_sel -> IR<=PB, -> S_BOTH.
//  - S_DROP: req/addr held; ack -> discard, fpc<=tgt, -> S_REQ. id_valid=0.
//  - Instruction never lost or duplicated under any id_ready / imem_ack pattern.
//  - pc_sel ignored when !consume. Reset mid-request abandons it; memory must tolerate req drop.
// CONFIGURATION
//  FETCH_ILLEGAL_TRAP_EN defined: IR loaded with opcode 13..15 -> id_valid forced 0,
//    illegal<=1 (sticky), -> S_HALT (req=0) until reset; PB/in-flight data discarded.
//  Undefined: opcodes 13..15 pass through as normal instructions; illegal tied 0; no S_HALT.
// STRUCTURE
//  cpu_pkg: OPC_W=4, INSTR_W=16, IMM_W=6, OPC_BEQZ=4'd12, OPC_ILL_MIN=4'd13,
//    fetch state encoding (S_IDLE,S_REQ,S_BOTH,S_FULL,S_DROP,S_HALT).
//  One sub-module natural: ifetch_branch_target (sext + add); rest inline.
// TESTING
//  1 Reset, ack every req cycle, id_ready=1 -> addr 0,1,2..; id_valid from cycle 3; 1 instr/cycle.
//  2 id_ready=0 for 5 cycles mid-stream -> PB fills, req=0 in S_FULL; sequence intact, no dup.
//  3 BEQZ at id_pc=4, imm=+3, pc_sel=1, ack same cycle -> rdata@5 dropped, next imem_addr=8.
//  4 Same branch, ack delayed 3 cycles -> S_DROP, imem_addr held 5 until ack, then 8; id_valid=0.
//  5 rst_n low mid-request -> imem_req/id_valid 0 immediately; after release, fetch from RESET_PC.
//  6 IR opcode 0xD: with FETCH_ILLEGAL_TRAP_EN -> illegal=1, id_valid=0, req=0 until reset;
//    without -> id_opcode=0xD presented with id_valid=1, illegal=0.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the 16-bit CPU instruction fetch stage.
// The optional illegal-opcode trap is enabled by defining FETCH_ILLEGAL_TRAP_EN.
package ifetch_unit_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IMM_W   = 6;

  localparam logic [OPC_W-1:0] OPC_BEQZ    = 4'd12;
  localparam logic [OPC_W-1:0] OPC_ILL_MIN = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BOTH,
    S_FULL,
    S_DROP,
    S_HALT
  } fetch_state_e;

  function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
    return opc >= OPC_ILL_MIN;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack port plus the decode-side
// valid/ready hand-off and the controller's branch select.
interface ifetch_unit_if
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned AW = 12
);

  logic               imem_req;
  logic [AW-1:0]      imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [OPC_W-1:0]   id_opcode;
  logic [AW-1:0]      id_pc;
  logic               pc_sel;

  // master: the fetch unit; slave: memory + controller side
  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
    input  imem_ack, imem_rdata, id_ready, pc_sel
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
    output imem_ack, imem_rdata, id_ready, pc_sel
  );

endinterface

// File: rtl/ifetch_branch_target.sv
// BEQZ target: pc + 1 + sign-extended 6-bit immediate, wrapping modulo 2^AW.
module ifetch_branch_target
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic [AW-1:0]    pc_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic [AW-1:0]    target_o
);

  logic [AW-1:0] imm_sext;

  always_comb begin
    imm_sext = {{(AW-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    target_o = pc_i + AW'(1) + imm_sext;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: IR + one-entry prefetch buffer, BEQZ redirect.
// Define FETCH_ILLEGAL_TRAP_EN to halt fetch on opcodes 13..15.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned   AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  ifetch_unit_if.master bus,
  output logic         illegal
);

`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e       state_q, state_d;
  logic [AW-1:0]      fpc_q, fpc_d;
  logic [AW-1:0]      tgt_q, tgt_d;
  logic [AW-1:0]      id_pc_q, id_pc_d;
  logic [AW-1:0]      pb_pc_q, pb_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [INSTR_W-1:0] pb_q, pb_d;
  logic               req_q, valid_q, illegal_q, illegal_d;

  logic               consume;
  logic               load_ir;
  logic [AW-1:0]      fpc_inc;
  logic [AW-1:0]      br_target;

  ifetch_branch_target #(.AW(AW)) u_br_target (
    .pc_i     (id_pc_q),
    .imm_i    (ir_q[IMM_W-1:0]),
    .target_o (br_target)
  );

  always_comb begin
    consume = valid_q & bus.id_ready;
    fpc_inc = fpc_q + AW'(1);
  end

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    tgt_d     = tgt_q;
    id_pc_d   = id_pc_q;
    pb_pc_d   = pb_pc_q;
    ir_d      = ir_q;
    pb_d      = pb_q;
    illegal_d = illegal_q;
    load_ir   = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          id_pc_d = fpc_q;
          fpc_d   = fpc_inc;
          load_ir = 1'b1;
          state_d = S_BOTH;
        end
      end

      S_BOTH: begin
        if (consume) begin
          if (bus.pc_sel) begin
            if (bus.imem_ack) begin
              fpc_d   = br_target;
              state_d = S_REQ;
            end else begin
              // Prefetch still in flight: remember where to go once it lands.
              tgt_d   = br_target;
              state_d = S_DROP;
            end
          end else if (bus.imem_ack) begin
            ir_d    = bus.imem_rdata;
            id_pc_d = fpc_q;
            fpc_d   = fpc_inc;
            load_ir = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else if (bus.imem_ack) begin
          pb_d    = bus.imem_rdata;
          pb_pc_d = fpc_q;
          fpc_d   = fpc_inc;
          state_d = S_FULL;
        end
      end

      S_FULL: begin
        if (consume) begin
          if (bus.pc_sel) begin
            fpc_d   = br_target;
            state_d = S_REQ;
          end else begin
            ir_d    = pb_q;
            id_pc_d = pb_pc_q;
            load_ir = 1'b1;
            state_d = S_BOTH;
          end
        end
      end

      S_DROP: begin
        if (bus.imem_ack) begin
          fpc_d   = tgt_q;
          state_d = S_REQ;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase

    if (TRAP_EN && load_ir && is_illegal(ir_d[INSTR_W-1:INSTR_W-OPC_W])) begin
      illegal_d = 1'b1;
      state_d   = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fpc_q     <= RESET_PC;
      tgt_q     <= '0;
      id_pc_q   <= '0;
      pb_pc_q   <= '0;
      ir_q      <= '0;
      pb_q      <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      tgt_q     <= tgt_d;
      id_pc_q   <= id_pc_d;
      pb_pc_q   <= pb_pc_d;
      ir_q      <= ir_d;
      pb_q      <= pb_d;
      illegal_q <= illegal_d;
      // Outputs decoded from the next state so they are registered.
      req_q     <= (state_d == S_REQ) || (state_d == S_BOTH) || (state_d == S_DROP);
      valid_q   <= (state_d == S_BOTH) || (state_d == S_FULL);
    end
  end

  always_comb begin
    bus.imem_req  = req_q;
    bus.imem_addr = fpc_q;
    bus.id_valid  = valid_q;
    bus.id_instr  = ir_q;
    bus.id_opcode = ir_q[INSTR_W-1:INSTR_W-OPC_W];
    bus.id_pc     = id_pc_q;
    illegal       = illegal_q;
  end

endmodule
